// File: rtl/guess_game_pkg.sv
// Shared types and default sizing for the guess-game controller.
package guess_game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    COMPARE = 3'd2,
    WIN     = 3'd3,
    LOSE    = 3'd4
  } state_t;

  localparam int DEF_WIDTH     = 3;
  localparam int DEF_MAX_TRIES = 5;
  localparam int DEF_TRY_W     = 3;

endpackage

// File: rtl/guess_game_ctrl_if.sv
// Player/comparator-facing bus of the guess-game controller.
// master = player and comparator side, slave = controller side.
interface guess_game_ctrl_if #(
  parameter int WIDTH = guess_game_pkg::DEF_WIDTH,
  parameter int TRY_W = guess_game_pkg::DEF_TRY_W
);
  logic [WIDTH-1:0] secret_in;
  logic             set_secret;
  logic [WIDTH-1:0] guess_in;
  logic             guess_valid;
  logic [WIDTH-1:0] cmp_left;
  logic [WIDTH-1:0] cmp_right;
  logic             cmp_gt;
  logic             cmp_eq;
  logic             cmp_lt;
  logic             ready;
  logic             led_high;
  logic             led_low;
  logic             led_win;
  logic             led_lose;
  logic [TRY_W-1:0] tries;
  logic             cmp_err;

  modport master (
    output secret_in, set_secret, guess_in, guess_valid, cmp_gt, cmp_eq, cmp_lt,
    input  cmp_left, cmp_right, ready, led_high, led_low, led_win, led_lose,
           tries, cmp_err
  );

  modport slave (
    input  secret_in, set_secret, guess_in, guess_valid, cmp_gt, cmp_eq, cmp_lt,
    output cmp_left, cmp_right, ready, led_high, led_low, led_win, led_lose,
           tries, cmp_err
  );
endinterface

// File: rtl/guess_game_ctrl.sv
// Guess-game controller: holds the secret, registers guesses into the
// external comparator, interprets its flags and drives the result LEDs.
module guess_game_ctrl
  import guess_game_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_TRIES = DEF_MAX_TRIES,
  parameter int TRY_W     = DEF_TRY_W
) (
  input  logic               clk,
  input  logic               rst_n,
  guess_game_ctrl_if.slave   bus
);

  localparam logic [TRY_W-1:0] MAX_T = TRY_W'(MAX_TRIES);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_left;
  logic [WIDTH-1:0] r_right;
  logic [TRY_W-1:0] r_tries;
  logic             r_high;
  logic             r_low;
  logic             r_win;
  logic             r_lose;
  logic             r_err;
  logic             w_onehot;
  logic             w_last_try;
  logic             w_ready;

  // Attempt counter must never wrap, even if MAX_TRIES is near the top.
  function automatic logic [TRY_W-1:0] sat_inc(input logic [TRY_W-1:0] v);
    return (v >= MAX_T) ? MAX_T : v + TRY_W'(1);
  endfunction

  assign w_onehot   = ({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} == 3'b100) ||
                      ({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} == 3'b010) ||
                      ({bus.cmp_gt, bus.cmp_eq, bus.cmp_lt} == 3'b001);
  assign w_last_try = (sat_inc(r_tries) == MAX_T);

  // State register; reset drops any game in progress, secret included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a new secret overrides everything, including a
  // comparison in flight or a guess arriving in the same cycle.
  always_comb begin
    w_next = r_state;
    if (bus.set_secret) begin
      w_next = ARMED;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        ARMED:   if (bus.guess_valid) w_next = COMPARE;
        COMPARE: begin
          if (!w_onehot)       w_next = ARMED;
          else if (bus.cmp_eq) w_next = WIN;
          else if (w_last_try) w_next = LOSE;
          else                 w_next = ARMED;
        end
        WIN:     w_next = WIN;
        LOSE:    w_next = LOSE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Output decode: guesses are accepted only while armed.
  always_comb begin
    w_ready = 1'b0;
    if (r_state == ARMED) w_ready = 1'b1;
  end

  // Operand, attempt counter, LED and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_left  <= '0;
      r_right <= '0;
      r_tries <= '0;
      r_high  <= 1'b0;
      r_low   <= 1'b0;
      r_win   <= 1'b0;
      r_lose  <= 1'b0;
      r_err   <= 1'b0;
    end else if (bus.set_secret) begin
      r_right <= bus.secret_in;
      r_tries <= '0;
      r_high  <= 1'b0;
      r_low   <= 1'b0;
      r_win   <= 1'b0;
      r_lose  <= 1'b0;
      r_err   <= 1'b0;
    end else if (r_state == ARMED && bus.guess_valid) begin
      r_left <= bus.guess_in;
    end else if (r_state == COMPARE) begin
      if (!w_onehot) begin
        r_err <= 1'b1;
      end else begin
        r_tries <= sat_inc(r_tries);
        if (bus.cmp_eq) begin
          r_win  <= 1'b1;
          r_high <= 1'b0;
          r_low  <= 1'b0;
        end else begin
          r_high <= bus.cmp_gt;
          r_low  <= bus.cmp_lt;
          if (w_last_try) r_lose <= 1'b1;
        end
      end
    end
  end

  assign bus.cmp_left  = r_left;
  assign bus.cmp_right = r_right;
  assign bus.ready     = w_ready;
  assign bus.led_high  = r_high;
  assign bus.led_low   = r_low;
  assign bus.led_win   = r_win;
  assign bus.led_lose  = r_lose;
  assign bus.tries     = r_tries;
  assign bus.cmp_err   = r_err;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Scoreboard bench for guess_game_ctrl with a behavioural 3-bit comparator.
module tb_guess_game_ctrl;

  typedef struct {
    int          cyc;
    string       name;
    logic [14:0] vec;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic force_bad = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  guess_game_ctrl_if #(.WIDTH(3), .TRY_W(3)) bus();

  guess_game_ctrl #(.WIDTH(3), .MAX_TRIES(5), .TRY_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // comparator beside the controller; force_bad injects non-one-hot flags
  assign bus.cmp_gt = force_bad ? 1'b1 : (bus.cmp_left >  bus.cmp_right);
  assign bus.cmp_lt = force_bad ? 1'b1 : (bus.cmp_left <  bus.cmp_right);
  assign bus.cmp_eq = force_bad ? 1'b0 : (bus.cmp_left == bus.cmp_right);

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [14:0] pack(input logic rdy, hi, lo, win, lose, err,
                                       input logic [2:0] tr, l, r);
    return {rdy, hi, lo, win, lose, err, tr, l, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // expectation for the negative edge of the current cycle
  task automatic expect_now(input string name, input logic rdy, hi, lo, win, lose, err,
                            input logic [2:0] tr, l, r);
    exp_t e;
    e.cyc  = cyc;
    e.name = name;
    e.vec  = pack(rdy, hi, lo, win, lose, err, tr, l, r);
    q.push_back(e);
  endtask

  task automatic do_set(input logic [2:0] v);
    bus.secret_in  = v;
    bus.set_secret = 1'b1;
    tick();
    bus.set_secret = 1'b0;
  endtask

  task automatic do_guess(input logic [2:0] v);
    bus.guess_in    = v;
    bus.guess_valid = 1'b1;
    tick();
    bus.guess_valid = 1'b0;
    tick();
  endtask

  // monitor: compares DUT outputs against the queued expectation for this cycle
  always @(negedge clk) begin
    logic [14:0] act;
    act = pack(bus.ready, bus.led_high, bus.led_low, bus.led_win, bus.led_lose,
               bus.cmp_err, bus.tries, bus.cmp_left, bus.cmp_right);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (e.cyc < cyc) begin
        failures++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", e.name, e.cyc, cyc);
      end else if (act !== e.vec) begin
        failures++;
        $display("FAIL %s: got rdy/hi/lo/win/lose/err=%b tries=%0d l=%0d r=%0d, want %b tries=%0d l=%0d r=%0d",
                 e.name, act[14:9], act[8:6], act[5:3], act[2:0],
                 e.vec[14:9], e.vec[8:6], e.vec[5:3], e.vec[2:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
    $fatal(1, "timeout");
  end

  initial begin
    bus.secret_in   = '0;
    bus.set_secret  = 1'b0;
    bus.guess_in    = '0;
    bus.guess_valid = 1'b0;
    tick(); tick();
    expect_now("reset", 0,0,0,0,0,0, 3'd0, 3'd0, 3'd0);
    tick();
    rst_n = 1'b1;
    // IDLE ignores guesses
    do_guess(3'd3);
    expect_now("idle_ignore", 0,0,0,0,0,0, 3'd0, 3'd0, 3'd0);

    // 1: direct win
    do_set(3'd5);
    expect_now("t1_armed", 1,0,0,0,0,0, 3'd0, 3'd0, 3'd5);
    bus.guess_in = 3'd5; bus.guess_valid = 1'b1; tick(); bus.guess_valid = 1'b0;
    expect_now("t1_compare", 0,0,0,0,0,0, 3'd0, 3'd5, 3'd5);
    tick();
    expect_now("t1_win", 0,0,0,1,0,0, 3'd1, 3'd5, 3'd5);
    do_guess(3'd3);
    expect_now("t1_win_hold", 0,0,0,1,0,0, 3'd1, 3'd5, 3'd5);

    // 2: low then high
    do_set(3'd5);
    expect_now("t2_armed_keepleft", 1,0,0,0,0,0, 3'd0, 3'd5, 3'd5);
    do_guess(3'd2);
    expect_now("t2_low", 1,0,1,0,0,0, 3'd1, 3'd2, 3'd5);
    do_guess(3'd7);
    expect_now("t2_high", 1,1,0,0,0,0, 3'd2, 3'd7, 3'd5);

    // 3: five misses with secret 0 lead to LOSE
    do_set(3'd0);
    expect_now("t3_armed", 1,0,0,0,0,0, 3'd0, 3'd7, 3'd0);
    do_guess(3'd1);
    expect_now("t3_miss1", 1,1,0,0,0,0, 3'd1, 3'd1, 3'd0);
    do_guess(3'd2);
    do_guess(3'd3);
    do_guess(3'd4);
    expect_now("t3_miss4", 1,1,0,0,0,0, 3'd4, 3'd4, 3'd0);
    do_guess(3'd6);
    expect_now("t3_lose", 0,1,0,0,1,0, 3'd5, 3'd6, 3'd0);
    do_guess(3'd0);
    expect_now("t3_lose_ignore", 0,1,0,0,1,0, 3'd5, 3'd6, 3'd0);

    // 4: set_secret and guess in the same cycle; then set_secret during COMPARE
    bus.secret_in = 3'd4; bus.set_secret = 1'b1;
    bus.guess_in  = 3'd4; bus.guess_valid = 1'b1;
    tick();
    bus.set_secret = 1'b0; bus.guess_valid = 1'b0;
    expect_now("t4_same_cycle", 1,0,0,0,0,0, 3'd0, 3'd6, 3'd4);
    tick();
    expect_now("t4_no_win", 1,0,0,0,0,0, 3'd0, 3'd6, 3'd4);
    bus.guess_in = 3'd4; bus.guess_valid = 1'b1; tick(); bus.guess_valid = 1'b0;
    bus.secret_in = 3'd1; bus.set_secret = 1'b1; tick(); bus.set_secret = 1'b0;
    expect_now("t4_set_in_compare", 1,0,0,0,0,0, 3'd0, 3'd4, 3'd1);
    tick();
    expect_now("t4_discarded", 1,0,0,0,0,0, 3'd0, 3'd4, 3'd1);

    // 5: non-one-hot flags set sticky cmp_err, tries unchanged
    force_bad = 1'b1;
    do_guess(3'd3);
    force_bad = 1'b0;
    expect_now("t5_err", 1,0,0,0,0,1, 3'd0, 3'd3, 3'd1);
    do_guess(3'd0);
    expect_now("t5_err_sticky", 1,0,1,0,0,1, 3'd1, 3'd0, 3'd1);
    do_set(3'd2);
    expect_now("t5_err_clear", 1,0,0,0,0,0, 3'd0, 3'd0, 3'd2);

    // 6: asynchronous reset in the middle of COMPARE
    bus.guess_in = 3'd6; bus.guess_valid = 1'b1; tick(); bus.guess_valid = 1'b0;
    #1 rst_n = 1'b0;
    expect_now("t6_async_reset", 0,0,0,0,0,0, 3'd0, 3'd0, 3'd0);
    tick(); tick();
    rst_n = 1'b1;
    do_guess(3'd2);
    expect_now("t6_idle_ignore", 0,0,0,0,0,0, 3'd0, 3'd0, 3'd0);

    tick(); tick();
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
